// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_multiport
// Brief    : Parametrised multi-read, dual-write register file with same-cycle
//            write bypass and a per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_multiport #(
  parameter int DATA_W    = 16,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_RD    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [NUM_REGS-1:0]      busy,
  output logic                     wr_conflict
);

  localparam bit HARD_ZERO  = (ZERO_REG0 != 0);
  localparam bit USE_BYPASS = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              same_idx;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      if (HARD_ZERO && i == 0) begin : g_zero
        assign regs[i] = '0;
        assign busy[i] = 1'b0;
      end else begin : g_live
        logic [DATA_W-1:0] q;
        logic              b;
        logic              hit0;
        logic              hit1;
        logic              hitr;

        assign hit0 = wr0_en && (wr0_addr == ADDR_W'(i));
        assign hit1 = wr1_en && (wr1_addr == ADDR_W'(i));
        assign hitr = rsv_en && (rsv_addr == ADDR_W'(i));

        // wr1 beats wr0 on a shared index; a reservation beats any write clear.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            q <= '0;
            b <= 1'b0;
          end else begin
            if (hit1)      q <= wr1_data;
            else if (hit0) q <= wr0_data;
            if (hitr)              b <= 1'b1;
            else if (hit0 || hit1) b <= 1'b0;
          end
        end

        assign regs[i] = q;
        assign busy[i] = b;
      end
    end
  endgenerate

  assign same_idx = wr0_en && wr1_en && (wr0_addr == wr1_addr) &&
                    !(HARD_ZERO && (wr0_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wr_conflict <= 1'b0;
    else      wr_conflict <= same_idx;
  end

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic              bz;
      logic              w0h;
      logic              w1h;
      logic              rh;

      assign a   = rd_addr[k*ADDR_W +: ADDR_W];
      assign w0h = wr0_en && (wr0_addr == a);
      assign w1h = wr1_en && (wr1_addr == a);
      assign rh  = rsv_en && (rsv_addr == a);

      // Reset and the hardwired zero register override everything, bypass included.
      always_comb begin
        d  = regs[a];
        bz = busy[a];
        if (USE_BYPASS) begin
          if (w1h)      d = wr1_data;
          else if (w0h) d = wr0_data;
          if ((w0h || w1h) && !rh) bz = 1'b0;
        end
        if (!rst || (HARD_ZERO && (a == '0))) begin
          d  = '0;
          bz = 1'b0;
        end
      end

      assign rd_data[k*DATA_W +: DATA_W] = d;
      assign rd_busy[k]                  = bz;
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised general-purpose register file. It is the next generation of the 16x16 two-read, one-write register file used in the CPU datapath. It adds configurable width, depth and read-port count, a second write port with a defined priority, same-cycle write-to-read bypass, and a per-register busy scoreboard for the pipeline hazard logic. Register 0 is optionally hardwired to zero.

Parameters:
DATA_W, 16, width of each register in bits.
NUM_REGS, 16, number of architectural registers; must be a power of two, minimum 2.
ADDR_W, 4, register index width; must equal log2(NUM_REGS).
NUM_RD, 2, number of read ports, 1 to 4.
BYPASS, 1, 1 = a same-cycle write is visible on the read ports; 0 = reads return stored contents only.
ZERO_REG0, 1, 1 = register 0 always reads 0 and is never written or reserved.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-low. Asserted (0) clears all state immediately.
rd_addr  in  NUM_RD*ADDR_W  read indices; port k uses bits [k*ADDR_W +: ADDR_W].
rd_data  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
rd_busy  out  NUM_RD  1 = the register addressed by port k has an outstanding reservation.
wr0_en  in  1  write port 0 enable.
wr0_addr  in  ADDR_W  write port 0 index.
wr0_data  in  DATA_W  write port 0 data.
wr1_en  in  1  write port 1 enable.
wr1_addr  in  ADDR_W  write port 1 index.
wr1_data  in  DATA_W  write port 1 data.
rsv_en  in  1  reserve request: mark rsv_addr busy.
rsv_addr  in  ADDR_W  index to reserve.
busy  out  NUM_REGS  registered scoreboard, one bit per register.
wr_conflict  out  1  registered one-cycle pulse flagging a dual write to the same index.

Behaviour:
- Reset (rst=0, asynchronous): all registers cleared to 0, busy cleared to all zeros, wr_conflict cleared to 0. While rst=0, rd_data is all zeros and rd_busy is all zeros; writes and reservations are ignored.
- Writes: on a rising edge with rst=1, each enabled port writes its data to its index. Write latency is 1 cycle.
- Dual write: if wr0_en and wr1_en are both set and wr0_addr==wr1_addr, wr1 wins and wr0 is dropped. wr_conflict is 1 for exactly the next cycle.
- wr_conflict is not raised when the common index is 0 with ZERO_REG0=1.
- Read: combinational from rd_addr. Read ports are independent; any ports may address the same register.
- Bypass, BYPASS=1: if an enabled write targets rd_addr[k] in the same cycle, rd_data[k] returns that write data. When both write ports match, wr1_data is returned. There is no path through any intermediate flop.
- Bypass, BYPASS=0: rd_data returns stored contents; a new value is visible the cycle after the write edge.
- ZERO_REG0=1: writes to index 0 are discarded, rd_data returns 0 for index 0 (bypass included), rsv_en to index 0 is ignored, and busy[0] is constant 0.
- ZERO_REG0=0: register 0 behaves like every other register.
- Scoreboard update per register i at each edge, highest priority first:
  1. rsv_en and rsv_addr==i sets busy[i]=1. This covers a simultaneous write to i: the new producer wins.
  2. Otherwise, any enabled write to i clears busy[i]=0.
  3. Otherwise busy[i] holds.
- Reserving an already-busy register keeps it busy; this is not an error.
- Writing a non-busy register is legal and leaves busy at 0.
- rd_busy[k] = busy[rd_addr[k]]. With BYPASS=1 it is forced to 0 when an enabled write to rd_addr[k] occurs that cycle and no same-cycle reservation of that index is in progress. With BYPASS=0 it is busy[rd_addr[k]] unmodified.
- Reset asserted mid-operation aborts any in-flight write. Nothing is committed on the edge coincident with or following reset assertion until rst returns to 1. The first write is honoured on the first rising edge with rst=1.
- Out-of-range indices cannot occur, because NUM_REGS = 2^ADDR_W.

Test Plan:
- Reset then read: pulse rst=0 between clock edges; all rd_data=16'h0000, busy=16'h0000, wr_conflict=0 immediately, without waiting for a clock edge.
- Write then read: wr0 writes 16'hFACE to r10; the next cycle rd port0 and port1 at r10 both return 16'hFACE. With BYPASS=1, the same-cycle read also returns 16'hFACE; with BYPASS=0 it returns 16'h0000.
- Dual-write conflict: wr0 writes 16'h1111 and wr1 writes 16'h2222, both to r5. r5 reads 16'h2222; wr_conflict=1 for exactly one cycle, then 0.
- Zero register, ZERO_REG0=1: write 16'h2222 to r0 and rsv_en to r0. rd_data=16'h0000 in the same cycle and the next cycle; busy[0] stays 0; wr_conflict stays 0 on a dual write to r0.
- Scoreboard: reserve r3, then busy[3]=1 and rd_busy=1 on a port reading r3. A write of 16'h0042 to r3 gives rd_busy=0 in the same cycle (BYPASS=1) and busy[3]=0 after the edge. A simultaneous reserve and write to r3 leaves busy[3]=1 with data 16'h0042 stored.
- Parametrisation: DATA_W=32, NUM_REGS=32, ADDR_W=5, NUM_RD=3. Write 32'hDEADBEEF to r31; all three ports read r31 and return 32'hDEADBEEF. Asserting rst=0 mid-write leaves r31 at 0.
